// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: grants up to DISPATCH_WIDTH of NUM_REQ
// functional-unit requesters per cycle onto registered ROB writeback ports.
module wb_arbiter #(
  parameter int NUM_REQ             = 4,
  parameter int DISPATCH_WIDTH      = 2,
  parameter int DISPATCH_ADDR_WIDTH = 1,
  parameter int ROB_ADDR_WIDTH      = 4,
  localparam int PW                 = $clog2(NUM_REQ)
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              flush,
  input  logic [NUM_REQ-1:0]                                req_valid,
  input  logic [NUM_REQ-1:0][DISPATCH_ADDR_WIDTH-1:0]       req_bank_addr,
  input  logic [NUM_REQ-1:0][ROB_ADDR_WIDTH-1:0]            req_rob_addr,
  output logic [NUM_REQ-1:0]                                req_ready,
  output logic [DISPATCH_WIDTH-1:0][DISPATCH_ADDR_WIDTH-1:0] writeback_bank_addr,
  output logic [DISPATCH_WIDTH-1:0][ROB_ADDR_WIDTH-1:0]      writeback_rob_addr,
  output logic [DISPATCH_WIDTH-1:0]                         writeback_en,
  output logic [15:0]                                       grant_count,
  output logic [PW-1:0]                                     rr_ptr
);

  // Handshake: requester i transfers in a cycle where req_valid[i] and
  // req_ready[i] are both high. req_ready is combinational and never high
  // without req_valid; the requester holds its request stable until transfer.

  localparam int MAXN = (NUM_REQ > DISPATCH_WIDTH) ? NUM_REQ : DISPATCH_WIDTH;
  localparam int CW   = $clog2(MAXN + 1);

  logic [PW:0]                                       sum;
  logic [PW-1:0]                                     idx;
  logic [PW-1:0]                                     last;
  logic [CW-1:0]                                     cnt;
  logic [DISPATCH_WIDTH-1:0]                         port_en_c;
  logic [DISPATCH_WIDTH-1:0][DISPATCH_ADDR_WIDTH-1:0] port_bank_c;
  logic [DISPATCH_WIDTH-1:0][ROB_ADDR_WIDTH-1:0]      port_rob_c;
  logic [PW:0]                                       ptr_sum;
  logic [PW-1:0]                                     ptr_next;
  logic [16:0]                                       gc_sum;
  logic [15:0]                                       gc_next;

  // Scan from rr_ptr in modular order; the k-th granted requester drives port k.
  always_comb begin
    req_ready   = '0;
    port_en_c   = '0;
    port_bank_c = '0;
    port_rob_c  = '0;
    cnt         = '0;
    last        = rr_ptr;
    sum         = '0;
    idx         = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(j);
      if (sum >= (PW+1)'(NUM_REQ)) begin
        sum = sum - (PW+1)'(NUM_REQ);
      end
      idx = sum[PW-1:0];
      if (rst && !flush && req_valid[idx] && (cnt < CW'(DISPATCH_WIDTH))) begin
        req_ready[idx] = 1'b1;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
          if (cnt == CW'(k)) begin
            port_en_c[k]   = 1'b1;
            port_bank_c[k] = req_bank_addr[idx];
            port_rob_c[k]  = req_rob_addr[idx];
          end
        end
        last = idx;
        cnt  = cnt + CW'(1);
      end
    end
  end

  always_comb begin
    ptr_next = rr_ptr;
    ptr_sum  = {1'b0, last} + (PW+1)'(1);
    if (ptr_sum >= (PW+1)'(NUM_REQ)) begin
      ptr_sum = '0;
    end
    if (cnt != '0) begin
      ptr_next = ptr_sum[PW-1:0];
    end
  end

  always_comb begin
    gc_sum  = {1'b0, grant_count} + 17'(cnt);
    gc_next = gc_sum[16] ? 16'hFFFF : gc_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      writeback_en        <= '0;
      writeback_bank_addr <= '0;
      writeback_rob_addr  <= '0;
      rr_ptr              <= '0;
      grant_count         <= '0;
    end else begin
      writeback_en <= port_en_c;
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        if (port_en_c[k]) begin
          writeback_bank_addr[k] <= port_bank_c[k];
          writeback_rob_addr[k]  <= port_rob_c[k];
        end
      end
      rr_ptr      <= ptr_next;
      grant_count <= gc_next;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: vector table for grant/port/pointer behaviour,
// plus hand sequences for asynchronous reset and grant_count saturation.
module tb_wb_arbiter;

  logic            clk;
  logic            rst;
  logic            flush;
  logic [3:0]      req_valid;
  logic [3:0][0:0] req_bank_addr;
  logic [3:0][3:0] req_rob_addr;
  logic [3:0]      req_ready;
  logic [1:0][0:0] writeback_bank_addr;
  logic [1:0][3:0] writeback_rob_addr;
  logic [1:0]      writeback_en;
  logic [15:0]     grant_count;
  logic [1:0]      rr_ptr;

  wb_arbiter dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush               (flush),
    .req_valid           (req_valid),
    .req_bank_addr       (req_bank_addr),
    .req_rob_addr        (req_rob_addr),
    .req_ready           (req_ready),
    .writeback_bank_addr (writeback_bank_addr),
    .writeback_rob_addr  (writeback_rob_addr),
    .writeback_en        (writeback_en),
    .grant_count         (grant_count),
    .rr_ptr              (rr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        flush;
    logic [3:0]  valid;
    logic [3:0]  bank;
    logic [15:0] rob;
    logic [3:0]  exp_ready;
    logic [1:0]  exp_en;
    logic [1:0]  exp_bank;
    logic [7:0]  exp_rob;
    logic [1:0]  exp_ptr;
  } vec_t;

  localparam int NVEC = 10;
  vec_t        tbl [NVEC];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] gc_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //               flush valid    bank     rob       ready    en     bank   rob    ptr
    tbl[0] = '{1'b0, 4'b1111, 4'b1010, 16'hDCBA, 4'b0011, 2'b11, 2'b10, 8'hBA, 2'd2};
    tbl[1] = '{1'b0, 4'b1111, 4'b1010, 16'hDCBA, 4'b1100, 2'b11, 2'b10, 8'hDC, 2'd0};
    tbl[2] = '{1'b0, 4'b0100, 4'b0100, 16'h0A00, 4'b0100, 2'b01, 2'b11, 8'hDA, 2'd3};
    tbl[3] = '{1'b0, 4'b1001, 4'b0001, 16'h5006, 4'b1001, 2'b11, 2'b10, 8'h65, 2'd1};
    tbl[4] = '{1'b1, 4'b1111, 4'b1111, 16'hFFFF, 4'b0000, 2'b00, 2'b10, 8'h65, 2'd1};
    tbl[5] = '{1'b0, 4'b1111, 4'b0101, 16'h4321, 4'b0110, 2'b11, 2'b10, 8'h32, 2'd3};
    tbl[6] = '{1'b0, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 2'b00, 2'b10, 8'h32, 2'd3};
    tbl[7] = '{1'b0, 4'b0010, 4'b0010, 16'h0070, 4'b0010, 2'b01, 2'b11, 8'h37, 2'd2};
    tbl[8] = '{1'b0, 4'b1011, 4'b1000, 16'h8009, 4'b1001, 2'b11, 2'b01, 8'h98, 2'd1};
    tbl[9] = '{1'b0, 4'b1000, 4'b0000, 16'hF000, 4'b1000, 2'b01, 2'b00, 8'h9F, 2'd0};

    rst           = 1'b0;
    flush         = 1'b0;
    req_valid     = 4'b1111;
    req_bank_addr = '1;
    req_rob_addr  = '1;
    gc_exp        = '0;

    // reset state, with requests pending
    #12;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_en", 32'(writeback_en), 32'h0);
    check("rst_bank", 32'(writeback_bank_addr), 32'h0);
    check("rst_rob", 32'(writeback_rob_addr), 32'h0);
    check("rst_ptr", 32'(rr_ptr), 32'h0);
    check("rst_gc", 32'(grant_count), 32'h0);

    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      flush         = tbl[i].flush;
      req_valid     = tbl[i].valid;
      req_bank_addr = tbl[i].bank;
      req_rob_addr  = tbl[i].rob;
      #1;
      check($sformatf("v%0d_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
      gc_exp = gc_exp + 16'($countones(tbl[i].exp_ready));
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_en", i), 32'(writeback_en), 32'(tbl[i].exp_en));
      check($sformatf("v%0d_bank", i), 32'(writeback_bank_addr), 32'(tbl[i].exp_bank));
      check($sformatf("v%0d_rob", i), 32'(writeback_rob_addr), 32'(tbl[i].exp_rob));
      check($sformatf("v%0d_ptr", i), 32'(rr_ptr), 32'(tbl[i].exp_ptr));
      check($sformatf("v%0d_gc", i), 32'(grant_count), 32'(gc_exp));
    end

    // asynchronous reset between edges while both ports are active
    flush         = 1'b0;
    req_valid     = 4'b1111;
    req_bank_addr = 4'b0011;
    req_rob_addr  = 16'h1234;
    @(posedge clk);
    #1;
    check("arst_pre_en", 32'(writeback_en), 32'h3);
    #1;
    rst = 1'b0;
    #1;
    check("arst_en", 32'(writeback_en), 32'h0);
    check("arst_gc", 32'(grant_count), 32'h0);
    check("arst_ptr", 32'(rr_ptr), 32'h0);
    check("arst_rob", 32'(writeback_rob_addr), 32'h0);
    check("arst_ready", 32'(req_ready), 32'h0);

    // saturation: two grants per cycle from zero
    @(negedge clk);
    rst = 1'b1;
    repeat (32767) @(posedge clk);
    @(negedge clk);
    check("sat_fffe", 32'(grant_count), 32'hFFFE);
    @(posedge clk);
    @(negedge clk);
    check("sat_ffff", 32'(grant_count), 32'hFFFF);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("sat_hold", 32'(grant_count), 32'hFFFF);
    check("sat_ready", 32'(req_ready), 32'(rr_ptr == 2'd0 ? 4'b0011 : 4'b1100));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of functional-unit writeback requesters, range 2..8.
REQ-002 Parameter DISPATCH_WIDTH, default 2: number of ROB writeback ports driven.
REQ-003 Parameter DISPATCH_ADDR_WIDTH, default 1: ROB bank address width.
REQ-004 Parameter ROB_ADDR_WIDTH, default 4: ROB entry address width within a bank.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous assertion, active-low (0 = reset).
REQ-007 flush  input  1  pipeline flush; drops all writebacks this cycle.
REQ-008 req_valid  input  [NUM_REQ]  requester i has a completed instruction.
REQ-009 req_bank_addr  input  [NUM_REQ] x DISPATCH_ADDR_WIDTH  ROB bank of requester i's instruction.
REQ-010 req_rob_addr  input  [NUM_REQ] x ROB_ADDR_WIDTH  ROB entry of requester i's instruction.
REQ-011 req_ready  output  [NUM_REQ]  requester i granted this cycle; combinational.
REQ-012 writeback_bank_addr  output  [DISPATCH_WIDTH] x DISPATCH_ADDR_WIDTH  registered, to ROB writeback port k.
REQ-013 writeback_rob_addr  output  [DISPATCH_WIDTH] x ROB_ADDR_WIDTH  registered, to ROB writeback port k.
REQ-014 writeback_en  output  [DISPATCH_WIDTH]  registered, port k carries a valid writeback.
REQ-015 grant_count  output  16  saturating count of accepted writebacks since reset.

Function
REQ-016 Transfer occurs for requester i when req_valid[i] and req_ready[i] are both 1 in the same cycle.
REQ-017 Requester holds req_valid, req_bank_addr and req_rob_addr stable until transfer; the arbiter does not check this.
REQ-018 Round-robin pointer rr_ptr (clog2(NUM_REQ) bits) marks the highest-priority requester.
REQ-019 Each cycle, scan indices rr_ptr, rr_ptr+1, ... mod NUM_REQ; first min(DISPATCH_WIDTH, number valid) valid requesters are granted.
REQ-020 The k-th grant in scan order (k = 0..DISPATCH_WIDTH-1) is assigned to writeback port k; unused ports carry writeback_en = 0.
REQ-021 req_ready[i] = 1 only when req_valid[i] = 1, flush = 0, rst = 1, and i is granted.
REQ-022 Granted addresses appear on writeback_* exactly one cycle after transfer; writeback_en[k] = 1 for that single cycle.
REQ-023 writeback_bank_addr/rob_addr of ports with writeback_en = 0 hold their previous value.
REQ-024 After at least one grant, rr_ptr becomes (index of last granted requester + 1) mod NUM_REQ; with no grant, rr_ptr unchanged.
REQ-025 When NUM_REQ valid requests <= DISPATCH_WIDTH, all are granted the same cycle.
REQ-026 A continuously valid requester is granted within ceil(NUM_REQ / DISPATCH_WIDTH) cycles.
REQ-027 flush = 1: all req_ready = 0, rr_ptr unchanged, writeback_en = 0 next cycle, grant_count unchanged.
REQ-028 flush does not cancel writebacks already registered; outputs registered the previous cycle are driven normally.
REQ-029 grant_count adds the number of transfers each cycle; saturates at 16'hFFFF, no wrap.

Reset
REQ-030 rst = 0 asynchronously forces writeback_en = all 0, writeback_bank_addr = 0, writeback_rob_addr = 0, rr_ptr = 0, grant_count = 0.
REQ-031 While rst = 0, req_ready = all 0; a transfer in progress when reset asserts is dropped, not replayed.
REQ-032 First grant possible in the first rising edge with rst = 1.

Verification
REQ-033 After reset, req_valid = 4'b1111 held 2 cycles -> cycle 0 ready = 4'b0011, cycle 1 ready = 4'b1100; ports next cycle carry req0/req1, then req2/req3; rr_ptr back to 0.
REQ-034 req_valid = 4'b0100, rob_addr[2] = 4'hA, bank_addr[2] = 1 -> ready = 4'b0100; next cycle writeback_en = 2'b01, port0 bank 1 / rob 4'hA; rr_ptr = 3.
REQ-035 rr_ptr = 3, req_valid = 4'b1001 -> port0 = req3, port1 = req0, rr_ptr = 1.
REQ-036 req_valid = 4'b1111 with flush = 1 -> ready = 0, next-cycle writeback_en = 0, rr_ptr and grant_count unchanged.
REQ-037 rst driven low mid-cycle with writeback_en = 2'b11 -> writeback_en = 0 immediately, before next clock; grant_count = 0.
REQ-038 grant_count preloaded near saturation via 32767 full-rate cycles -> count reaches 16'hFFFF and stays.
